// File: rtl/mw_ppa_pkg.sv
// Shared types and defaults for the multi-word sequential prefix adder.
package mw_ppa_pkg;

  localparam int WORD_W_DEF = 24;
  localparam int NWORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/mw_ppa_seq_adder_bk.sv
// Brent-Kung parallel-prefix adder slice: sum/cout of a + b + cin over WIDTH bits (WIDTH >= 2).
module PPA_Brent_Kung_24bit #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] gfin;

  // Folding cin into bit 0's generate lets every group carry include it.
  always_comb begin
    p0    = a ^ b;
    g0    = a & b;
    g0[0] = g0[0] | (p0[0] & cin);
  end

  for (genvar l = 0; l < LEVELS; l++) begin : up
    logic [WIDTH-1:0] gi, pi, g, p;
    if (l == 0) begin : src0
      assign gi = g0;
      assign pi = p0;
    end else begin : srcn
      assign gi = up[l-1].g;
      assign pi = up[l-1].p;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : bitl
      if (((i + 1) % (2 << l)) == 0) begin : node
        assign g[i] = gi[i] | (pi[i] & gi[i - (1 << l)]);
        assign p[i] = pi[i] & pi[i - (1 << l)];
      end else begin : pass
        assign g[i] = gi[i];
        assign p[i] = pi[i];
      end
    end
  end

  // Down-sweep fills the prefixes the up-sweep tree left partial.
  for (genvar d = 0; d < LEVELS; d++) begin : down
    localparam int L = LEVELS - 1 - d;
    logic [WIDTH-1:0] gi, g;
    if (d == 0) begin : src0
      assign gi = up[LEVELS-1].g;
    end else begin : srcn
      assign gi = down[d-1].g;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : bitd
      if ((((i + 1) % (2 << L)) == (1 << L)) && ((i + 1) >= 3 * (1 << L))) begin : node
        assign g[i] = gi[i] | (up[LEVELS-1].p[i] & gi[i - (1 << L)]);
      end else begin : pass
        assign g[i] = gi[i];
      end
    end
  end

  assign gfin = down[LEVELS-1].g;
  assign sum  = p0 ^ {gfin[WIDTH-2:0], cin};
  assign cout = gfin[WIDTH-1];

endmodule

// File: rtl/mw_ppa_seq_adder.sv
// Word-serial multi-word adder chaining carry through one prefix-adder slice.
// Optional subtract mode enabled by defining MWADD_SUB_EN.
module mw_ppa_seq_adder
  import mw_ppa_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W*NWORDS-1:0] in_a,
  input  logic [WORD_W*NWORDS-1:0] in_b,
  input  logic                     in_cin,
`ifdef MWADD_SUB_EN
  input  logic                     in_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W*NWORDS-1:0] out_sum,
  output logic                     out_cout
);

  localparam int TOT_W = WORD_W * NWORDS;
  localparam int IDX_W = idx_width(NWORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx;
  logic              carry_q;
  logic [TOT_W-1:0]  a_q, b_q;
  logic [WORD_W-1:0] a_words   [NWORDS];
  logic [WORD_W-1:0] b_words   [NWORDS];
  logic [WORD_W-1:0] sum_words [NWORDS];
  logic [WORD_W-1:0] a_word, b_word, slice_sum;
  logic              slice_cout;
  logic              accept, last;

  for (genvar k = 0; k < NWORDS; k++) begin : words
    assign a_words[k]                   = a_q[k*WORD_W +: WORD_W];
    assign b_words[k]                   = b_q[k*WORD_W +: WORD_W];
    assign out_sum[k*WORD_W +: WORD_W]  = sum_words[k];
  end

`ifdef MWADD_SUB_EN
  logic sub_q;
  assign b_word = sub_q ? ~b_words[idx] : b_words[idx];
`else
  assign b_word = b_words[idx];
`endif
  assign a_word = a_words[idx];

  PPA_Brent_Kung_24bit #(.WIDTH(WORD_W)) u_slice (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx == LAST_IDX);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = in_valid ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A new accept always wins over word processing; the two never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry_q  <= 1'b0;
      out_cout <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      for (int k = 0; k < NWORDS; k++) sum_words[k] <= '0;
`ifdef MWADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
        idx <= '0;
`ifdef MWADD_SUB_EN
        sub_q   <= in_sub;
        carry_q <= in_sub ? 1'b1 : in_cin;
`else
        carry_q <= in_cin;
`endif
      end else if (state == RUN) begin
        sum_words[idx] <= slice_sum;
        carry_q        <= slice_cout;
        if (last) begin
          idx      <= '0;
          out_cout <= slice_cout;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
